spi_dcs_burst_if: RTL and testbench
===================================

// Module: spi_dcs_burst_if
// PURPOSE
//  SPI slave, dual chip-select (address CS / data CS), all four SPI modes, burst transfers.
//  Address phase loads a base address. A data phase then streams words.
//  Each completed word gives one write strobe; the word address auto-increments.
//  Read data is prefetched from the SRAM-like side so SDO streams back-to-back.
//  Sits between the MCU SPI pins and the FPGA register file / SRAM-like bus.
// PARAMETERS
//  AW       8   address width (bits shifted per address phase)
//  DW       16  data word width
//  CPOL     0   SCL idle level
//  CPHA     0   0: sample on leading edge, 1: sample on trailing edge
//  ADDR_INC 1   1: word address +1 per word (mod 2^AW); 0: fixed address
// PORTS
//  clk          in   1   system clock; SCL <= clk/8
//  rst_n        in   1   async active-low reset
//  spi_scl      in   1   SPI clock (async)
//  spi_sdi      in   1   MOSI, MSB first
//  spi_sdo      out  1   MISO, MSB first, registered
//  spi_cs_addr  in   1   address-phase select, active low
//  spi_cs_data  in   1   data-phase select, active low
//  Wr_en        out  1   1-cycle pulse: Wdata valid for Wr_addr
//  Wr_addr      out  AW  write word address
//  Wdata        out  DW  received word
//  Rd_en        out  1   1-cycle read request for Rd_addr
//  Rd_addr      out  AW  read address
//  Rdata        in   DW  read data, valid 1 clk after Rd_en
//  Burst_begin  out  1   1-cycle pulse on entry to DATA
//  Burst_end    out  1   1-cycle pulse on exit from DATA
//  Addr_err     out  1   1-cycle pulse: address phase bit count != AW
// BEHAVIOUR
//  - Reset: every output 0; SCL sync regs = CPOL; CS sync regs = 1; state IDLE; base = 0.
//  - Synchronisers: SCL and both CS go through 2-FF sync plus edge detect; 2-cycle input latency.
//  - Leading edge = rising if CPOL=0, else falling. Sample edge = leading (CPHA=0) or trailing (CPHA=1).
//    Drive edge = the other edge.
//  - FSM IDLE/ADDR/DATA:
//    IDLE->ADDR on cs_addr fall. IDLE->DATA on cs_data fall.
//    If both fall in the same cycle, ADDR wins; cs_data is then ignored until its next fall.
//  - A CS edge for the inactive phase is ignored outside IDLE.
//  - ADDR: shift SDI in on each sample edge; count bits, saturating at AW+1.
//    On cs_addr rise: count == AW -> base <= shift reg; else base kept and Addr_err pulses.
//    Go to IDLE.
//  - DATA entry (cs_data fall cycle):
//    Burst_begin=1, Rd_en=1, Rd_addr=base, word_addr<=base, bit_cnt<=0.
//    Next clk: tx_sr <= Rdata, so SDO = MSB before the first SCL edge.
//  - Each sample edge: rx_sr <= {rx_sr, sdi}; bit_cnt wraps at DW.
//    On bit 0 of each word, the next clk issues prefetch: Rd_en=1, Rd_addr = word_addr+ADDR_INC.
//    Rdata is captured into pre_buf one clk later.
//  - DW-th sample edge: next clk Wr_en=1, Wr_addr=word_addr, Wdata=completed word.
//    In the clk after that, word_addr += ADDR_INC, wrapping mod 2^AW.
//  - Drive edge:
//    bit_cnt != 0 -> shift tx_sr, SDO = new MSB.
//    bit_cnt == 0 and >=1 word completed -> tx_sr <= pre_buf.
//    Otherwise (CPHA=1, first leading edge) -> hold.
//  - cs_data rise: Burst_end=1; partial word discarded (no Wr_en); SDO=0; go to IDLE.
//    Burst_end may coincide with Wr_en of the last word.
//  - SDO is 0 whenever state != DATA. Rd_en and Wr_en are never high in the same cycle.
//  - rst_n low mid-burst: immediate return to reset values; no strobes; base cleared.
// TESTING
//  1 Mode0: addr 0x12; burst-write 0xA5A5,0x0001,0xFFFF ->
//    Wr_en x3 at addrs 0x12,0x13,0x14 with those data; Burst_begin/Burst_end once each.
//  2 Mode3, ADDR_INC=1: base 0xFE; Rdata model mem[a]=a*3; read 3 words ->
//    SDO streams 0x02FA,0x02FD,0x0000 (addr wraps 0xFF->0x00); gapless.
//  3 Address phase of 5 bits (AW=8) -> Addr_err pulse; next write goes to previous base.
//  4 cs_data rises after 9 bits of word 2 -> only 1 Wr_en; Burst_end; SDO=0 next clk.
//  5 ADDR_INC=0, modes 1 and 2: 4-word write -> all Wr_addr = base; full-duplex SDO = mem[base] each word.
//  6 rst_n asserted mid-word, then released, then clean burst at 0x40 ->
//    no stale strobe; writes land at 0x40.

Source files
------------

// File: rtl/spi_dcs_burst_if.sv
// SPI slave with separate address/data chip-selects and burst word streaming.
// The address phase loads a base address; the data phase writes words and prefetches read data.
module spi_dcs_burst_if #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 16,
  parameter bit          CPOL     = 1'b0,
  parameter bit          CPHA     = 1'b0,
  parameter bit          ADDR_INC = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spi_scl,
  input  logic          spi_sdi,
  output logic          spi_sdo,
  input  logic          spi_cs_addr,
  input  logic          spi_cs_data,
  output logic          Wr_en,
  output logic [AW-1:0] Wr_addr,
  output logic [DW-1:0] Wdata,
  output logic          Rd_en,
  output logic [AW-1:0] Rd_addr,
  input  logic [DW-1:0] Rdata,
  output logic          Burst_begin,
  output logic          Burst_end,
  output logic          Addr_err
);

  localparam int unsigned   BW   = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned   CW   = $clog2(AW + 2);
  localparam logic [AW-1:0] STEP = AW'(ADDR_INC);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, nstate;

  logic [2:0]    scl_q, csa_q, csd_q;
  logic [1:0]    sdi_q;
  logic          scl_rise, scl_fall, lead, trail, sample, drive;
  logic          csa_fall, csa_rise, csd_fall, csd_rise, sdi_s;
  logic          entry;

  logic [AW-1:0] base, word_addr, a_sr;
  logic [CW-1:0] a_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] rx_sr, tx_sr, tx_nxt, pre_buf;
  logic          words_done, rd_first, rd_pend, rd_pend_first;

  // Two-stage synchronisers; the third stage is the previous value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= {3{CPOL}};
      csa_q <= '1;
      csd_q <= '1;
      sdi_q <= '0;
    end else begin
      scl_q <= {scl_q[1:0], spi_scl};
      csa_q <= {csa_q[1:0], spi_cs_addr};
      csd_q <= {csd_q[1:0], spi_cs_data};
      sdi_q <= {sdi_q[0], spi_sdi};
    end
  end

  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign lead     = CPOL ? scl_fall : scl_rise;
  assign trail    = CPOL ? scl_rise : scl_fall;
  assign sample   = CPHA ? trail : lead;
  assign drive    = CPHA ? lead : trail;
  assign csa_fall = ~csa_q[1] & csa_q[2];
  assign csa_rise = csa_q[1] & ~csa_q[2];
  assign csd_fall = ~csd_q[1] & csd_q[2];
  assign csd_rise = csd_q[1] & ~csd_q[2];
  assign sdi_s    = sdi_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    entry  = 1'b0;
    case (state)
      IDLE: begin
        if (csa_fall) nstate = ADDR;
        else if (csd_fall) begin
          nstate = DATA;
          entry  = 1'b1;
        end
      end
      ADDR:    if (csa_rise) nstate = IDLE;
      DATA:    if (csd_rise) nstate = IDLE;
      default: nstate = IDLE;
    endcase

    tx_nxt = tx_sr;
    if (entry) tx_nxt = '0;
    else if (rd_pend && rd_pend_first) tx_nxt = Rdata;
    else if (state == DATA && drive) begin
      if (bit_cnt != '0)   tx_nxt = {tx_sr[DW-2:0], 1'b0};
      else if (words_done) tx_nxt = pre_buf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Wr_en         <= 1'b0;
      Wr_addr       <= '0;
      Wdata         <= '0;
      Rd_en         <= 1'b0;
      Rd_addr       <= '0;
      Burst_begin   <= 1'b0;
      Burst_end     <= 1'b0;
      Addr_err      <= 1'b0;
      spi_sdo       <= 1'b0;
      base          <= '0;
      word_addr     <= '0;
      a_sr          <= '0;
      a_cnt         <= '0;
      bit_cnt       <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      pre_buf       <= '0;
      words_done    <= 1'b0;
      rd_first      <= 1'b0;
      rd_pend       <= 1'b0;
      rd_pend_first <= 1'b0;
    end else begin
      Wr_en         <= 1'b0;
      Rd_en         <= 1'b0;
      Burst_begin   <= 1'b0;
      Burst_end     <= 1'b0;
      Addr_err      <= 1'b0;
      rd_pend       <= Rd_en;
      rd_pend_first <= Rd_en & rd_first;
      tx_sr         <= tx_nxt;
      spi_sdo       <= (nstate == DATA) ? tx_nxt[DW-1] : 1'b0;

      // Read data lands one clock after the request; only prefetches go to pre_buf.
      if (rd_pend && !rd_pend_first) pre_buf <= Rdata;

      case (state)
        IDLE: begin
          if (csa_fall) begin
            a_sr  <= '0;
            a_cnt <= '0;
          end else if (csd_fall) begin
            Burst_begin <= 1'b1;
            Rd_en       <= 1'b1;
            Rd_addr     <= base;
            rd_first    <= 1'b1;
            word_addr   <= base;
            bit_cnt     <= '0;
            words_done  <= 1'b0;
          end
        end
        ADDR: begin
          if (csa_rise) begin
            if (a_cnt == CW'(AW)) base <= a_sr;
            else                  Addr_err <= 1'b1;
          end else if (sample) begin
            a_sr <= {a_sr[AW-2:0], sdi_s};
            if (a_cnt != CW'(AW + 1)) a_cnt <= a_cnt + CW'(1);
          end
        end
        DATA: begin
          if (Wr_en) word_addr <= word_addr + STEP;
          if (sample) begin
            rx_sr   <= {rx_sr[DW-2:0], sdi_s};
            bit_cnt <= (bit_cnt == BW'(DW - 1)) ? '0 : bit_cnt + BW'(1);
            if (bit_cnt == '0) begin
              Rd_en    <= 1'b1;
              Rd_addr  <= word_addr + STEP;
              rd_first <= 1'b0;
            end
            if (bit_cnt == BW'(DW - 1)) begin
              Wr_en      <= 1'b1;
              Wr_addr    <= word_addr;
              Wdata      <= {rx_sr[DW-2:0], sdi_s};
              words_done <= 1'b1;
            end
          end
          if (csd_rise) Burst_end <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_dcs_burst_if.sv
// Bench for spi_dcs_burst_if: four instances cover SPI modes 0/3/1/2 and fixed/incrementing addressing.
module tb_spi_dcs_burst_if;

  localparam logic [3:0] CP  = 4'b1010;
  localparam logic [3:0] CH  = 4'b0110;
  localparam logic [3:0] INC = 4'b0011;

  logic        clk = 1'b0, rst_n = 1'b0, sck = 1'b0, sdi = 1'b0;
  logic [3:0]  csa = '1, csd = '1;
  logic [3:0]  sdo, wr_en, rd_en, bb, be, ae;
  logic [7:0]  wr_addr [4];
  logic [7:0]  rd_addr [4];
  logic [15:0] wdata [4];
  logic [15:0] rdata [4] = '{default: '0};

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cur = 0, cur_cpha = 0;
  logic [27:0] obs [256];
  int obs_n = 0, rd_ptr = 0, ovl_cnt = 0;
  int bb_cnt [4] = '{default: 0};
  int be_cnt [4] = '{default: 0};
  int ae_cnt [4] = '{default: 0};
  logic [27:0] wq [$];
  logic [15:0] txq [$];
  logic [15:0] rq [$];
  logic [15:0] rx;
  int a0, b0, e0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_dcs_burst_if #(.AW(8), .DW(16), .CPOL(CP[g]), .CPHA(CH[g]), .ADDR_INC(INC[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .spi_scl(sck ^ CP[g]), .spi_sdi(sdi), .spi_sdo(sdo[g]),
      .spi_cs_addr(csa[g]), .spi_cs_data(csd[g]),
      .Wr_en(wr_en[g]), .Wr_addr(wr_addr[g]), .Wdata(wdata[g]),
      .Rd_en(rd_en[g]), .Rd_addr(rd_addr[g]), .Rdata(rdata[g]),
      .Burst_begin(bb[g]), .Burst_end(be[g]), .Addr_err(ae[g]));
  end

  // Memory model: mem[a] = a*3, returned one clock after the request.
  always @(posedge clk)
    for (int g = 0; g < 4; g++)
      if (rd_en[g] === 1'b1) rdata[g] <= 16'(rd_addr[g]) * 16'd3;

  always @(negedge clk)
    for (int g = 0; g < 4; g++) begin
      if (wr_en[g] === 1'b1) begin
        obs[obs_n] = {4'(g), wr_addr[g], wdata[g]};
        obs_n = obs_n + 1;
      end
      if (bb[g] === 1'b1) bb_cnt[g] = bb_cnt[g] + 1;
      if (be[g] === 1'b1) be_cnt[g] = be_cnt[g] + 1;
      if (ae[g] === 1'b1) ae_cnt[g] = ae_cnt[g] + 1;
      if (wr_en[g] === 1'b1 && rd_en[g] === 1'b1) ovl_cnt = ovl_cnt + 1;
    end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input int n, input logic [15:0] tx, output logic [15:0] rxo);
    rxo = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (cur_cpha == 0) begin
        sdi = tx[i]; clks(8); sck = 1'b1; rxo[i] = sdo[cur]; clks(8); sck = 1'b0;
      end else begin
        sck = 1'b1; sdi = tx[i]; clks(8); sck = 1'b0; rxo[i] = sdo[cur]; clks(8);
      end
    end
  endtask

  task automatic addr_phase(input int g, input int n, input logic [15:0] a);
    logic [15:0] dummy;
    cur = g; cur_cpha = int'(CH[g]);
    csa[g] = 1'b0; clks(16);
    send_bits(n, a, dummy);
    clks(16); csa[g] = 1'b1; clks(16);
  endtask

  task automatic word(input int g, input logic [7:0] a, input logic [15:0] d, input logic [15:0] r);
    txq.push_back(d);
    rq.push_back(r);
    wq.push_back({4'(g), a, d});
  endtask

  task automatic check_writes();
    int n_obs = obs_n - rd_ptr;
    chk("write_count", n_obs, wq.size());
    while (rd_ptr < obs_n && wq.size() > 0) begin
      chk("write", {4'h0, obs[rd_ptr]}, {4'h0, wq.pop_front()});
      rd_ptr++;
    end
    rd_ptr = obs_n;
    wq.delete();
  endtask

  task automatic burst(input int g, input int nw);
    logic [15:0] r, e;
    int bs, es;
    cur = g; cur_cpha = int'(CH[g]);
    bs = bb_cnt[g]; es = be_cnt[g];
    csd[g] = 1'b0; clks(16);
    for (int w = 0; w < nw; w++) begin
      send_bits(16, txq.pop_front(), r);
      e = rq.pop_front();
      chk("sdo_word", {16'h0, r}, {16'h0, e});
    end
    clks(16); csd[g] = 1'b1; clks(16);
    chk("sdo_idle", sdo[g], 0);
    chk("burst_begin", bb_cnt[g] - bs, 1);
    chk("burst_end", be_cnt[g] - es, 1);
    check_writes();
  endtask

  initial begin
    rst_n = 1'b0; clks(5); rst_n = 1'b1; clks(5);
    chk("reset_strobes", {8'h0, sdo, wr_en, rd_en, bb, be, ae}, 0);
    chk("reset_buses", {wr_addr[0], rd_addr[0], wdata[0]}, 0);

    // Mode 0 burst write at 0x12
    a0 = ae_cnt[0];
    addr_phase(0, 8, 16'h0012);
    chk("addr_ok", ae_cnt[0] - a0, 0);
    word(0, 8'h12, 16'hA5A5, 16'h0036);
    word(0, 8'h13, 16'h0001, 16'h0039);
    word(0, 8'h14, 16'hFFFF, 16'h003C);
    burst(0, 3);

    // Mode 3 read stream across the 0xFF->0x00 wrap
    addr_phase(1, 8, 16'h00FE);
    word(1, 8'hFE, 16'h0000, 16'h02FA);
    word(1, 8'hFF, 16'h0000, 16'h02FD);
    word(1, 8'h00, 16'h0000, 16'h0000);
    burst(1, 3);

    // Short address phase keeps the previous base
    a0 = ae_cnt[0];
    addr_phase(0, 5, 16'h0015);
    chk("addr_err", ae_cnt[0] - a0, 1);
    word(0, 8'h12, 16'h1234, 16'h0036);
    burst(0, 1);

    // Burst cut after 9 bits of the second word
    addr_phase(0, 8, 16'h0020);
    cur = 0; cur_cpha = 0;
    b0 = bb_cnt[0]; e0 = be_cnt[0];
    wq.push_back({4'h0, 8'h20, 16'hBEEF});
    csd[0] = 1'b0; clks(16);
    send_bits(16, 16'hBEEF, rx);
    chk("sdo_word_cut", rx, 16'h0060);
    send_bits(9, 16'h0155, rx);
    clks(8);
    chk("sdo_partial", sdo[0], 1);
    csd[0] = 1'b1; clks(6);
    chk("sdo_after_end", sdo[0], 0);
    clks(10);
    chk("cut_begin", bb_cnt[0] - b0, 1);
    chk("cut_end", be_cnt[0] - e0, 1);
    check_writes();

    // Fixed address, mode 1 and mode 2
    addr_phase(2, 8, 16'h0021);
    word(2, 8'h21, 16'h1111, 16'h0063);
    word(2, 8'h21, 16'h2222, 16'h0063);
    word(2, 8'h21, 16'h3333, 16'h0063);
    word(2, 8'h21, 16'h4444, 16'h0063);
    burst(2, 4);
    addr_phase(3, 8, 16'h0005);
    word(3, 8'h05, 16'hAAAA, 16'h000F);
    word(3, 8'h05, 16'h5555, 16'h000F);
    word(3, 8'h05, 16'h0F0F, 16'h000F);
    word(3, 8'h05, 16'hF0F0, 16'h000F);
    burst(3, 4);

    // Reset in the middle of a word
    cur = 0; cur_cpha = 0;
    e0 = be_cnt[0];
    csd[0] = 1'b0; clks(16);
    send_bits(7, 16'h007F, rx);
    rst_n = 1'b0; clks(2);
    chk("reset_mid", {sdo[0], wr_en[0], rd_en[0], bb[0], be[0]}, 0);
    csd[0] = 1'b1; clks(10);
    rst_n = 1'b1; clks(16);
    chk("no_stale_write", obs_n - rd_ptr, 0);
    chk("no_end_after_reset", be_cnt[0] - e0, 0);
    word(0, 8'h00, 16'h5A5A, 16'h0000);
    burst(0, 1);
    addr_phase(0, 8, 16'h0040);
    word(0, 8'h40, 16'hC0DE, 16'h00C0);
    word(0, 8'h41, 16'h0BAD, 16'h00C3);
    burst(0, 2);

    chk("rd_wr_overlap", ovl_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
